btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Multi-channel push-button conditioner: the parametrised successor of the single-channel oneshot strobe generator. Each channel synchronises a raw button input, debounces it with a stability counter, and emits a one-cycle press strobe, an optional auto-repeat strobe train while held, and a one-cycle release strobe. It sits between board-level button pins and control logic that consumes single-cycle events.

## Interface

- `CHANNELS`, default 4: number of independent button channels; must be ≥ 1.
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles the synchronised input must differ from the debounced level before the level changes; must be ≥ 1.
- `REPEAT_EN`, default 1: 1 enables auto-repeat; 0 gives press and release strobes only.
- `REPEAT_DELAY`, default 1000: cycles from the press strobe to the first repeat strobe; must be ≥ 1.
- `REPEAT_PERIOD`, default 250: cycles between successive repeat strobes; must be ≥ 1.

Ports:

- `clk_i` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_ni` input, 1 bit: reset, synchronous and active-low.
- `btn_i` input, `CHANNELS` bits: raw asynchronous button levels, 1 = pressed.
- `lvl_o` output, `CHANNELS` bits: debounced level per channel.
- `stb_o` output, `CHANNELS` bits: one-cycle strobe on each press and on each auto-repeat.
- `rel_o` output, `CHANNELS` bits: one-cycle strobe on each debounced release.

## Operation

Channels are fully independent; each channel replicates the logic below.

- **Synchroniser:** two flops, `s1` then `s`, sample `btn_i[c]`.
- **Debounce counter:** `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s == lvl`: `cnt` ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `lvl` ← `s` and `cnt` ← 0.
  - Else: `cnt` ← `cnt+1`.
  - Any cycle where `s` returns to `lvl` clears `cnt`. A glitch shorter than `DEBOUNCE_CYCLES` therefore produces no event.
- **Event FSM:** states IDLE, HELD, REPEAT. All outputs are registered.
  - IDLE → HELD on a `lvl` rising transition. `stb_o` = 1 for that cycle. `rcnt` ← `REPEAT_DELAY-1`.
  - HELD: `rcnt` decrements each cycle. When `rcnt == 0` and `REPEAT_EN = 1`, pulse `stb_o`, load `rcnt` ← `REPEAT_PERIOD-1`, and go to REPEAT. With `REPEAT_EN = 0`, the FSM stays in HELD and never repeats.
  - REPEAT: `rcnt` decrements each cycle. When `rcnt == 0`, pulse `stb_o` and reload `REPEAT_PERIOD-1`.
  - HELD or REPEAT → IDLE on a `lvl` falling transition. `rel_o` = 1 for that cycle and `rcnt` is cleared.
  - If a repeat expiry coincides with the release transition, the release wins: `rel_o` = 1 and `stb_o` = 0.
  - `stb_o` and `rel_o` are never high together on the same channel.
- **Repeat counter:** `rcnt` width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD))`, minimum 1 bit.
  - With `REPEAT_PERIOD = 1`, repeats occur every cycle.
  - With `REPEAT_DELAY = 1`, the first repeat falls on the cycle after the press strobe.
- **Reset** (`rst_ni = 0` at a rising edge):
  - All outputs, synchroniser flops, `lvl`, `cnt` and `rcnt` go to 0, and the FSM goes to IDLE.
  - This applies mid-operation too: outputs are 0 on the cycle after the reset edge.
  - A button held through reset release is treated as a new press. It is debounced and strobed normally.
- **Unsupported values:** out-of-range parameters are unsupported. The implementation contains elaboration-time assertions for them.

## Timing

Edges are counted from the first rising edge that samples the new `btn_i` value, which is edge 1.

- **Press latency:** after a clean transition, `s` changes at edge 2, and `lvl_o` and `stb_o` rise at edge `DEBOUNCE_CYCLES+2`. `stb_o` is high for exactly one cycle.
- **Release latency:** `lvl_o` falls and `rel_o` pulses at edge `DEBOUNCE_CYCLES+2` of the release transition.
- **Repeat schedule:** if the press strobe is at edge P, repeats occur at P+`REPEAT_DELAY`, then every `REPEAT_PERIOD` edges after that, until release.
- **Minimum event spacing:** press to release requires the held level to persist for at least `DEBOUNCE_CYCLES` synchronised cycles. Events on one channel are therefore at least `DEBOUNCE_CYCLES` cycles apart, excluding repeats.
- **No handshake:** strobes are fire-and-forget. Consumers sample them every cycle.

## Test plan

Bench parameters: `CHANNELS=2`, `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=3`.

1. **Reset:** hold `rst_ni` low for 3 cycles with `btn_i = 2'b11` → all outputs are 0 throughout. After release, `stb_o = 2'b11` at edge 6 relative to the first post-reset edge.
2. **Clean press and hold:** `btn_i[0]` high from edge 1, held 30 cycles → `lvl_o[0]` rises at edge 6. `stb_o[0]` is high at edges 6, 16, 19, 22, 25, 28. `stb_o[1]`, `lvl_o[1]` and `rel_o` stay 0.
3. **Bounce:** `btn_i[0]` toggles every 2 cycles for 12 cycles, then settles high → exactly one `stb_o[0]` pulse, at 6 edges after settling.
4. **Glitch and release:**
   - A 3-cycle high glitch produces no output.
   - Release after a hold makes `rel_o[0]` pulse 6 edges after the falling edge, and no further `stb_o[0]` pulses follow.
   - With release timed so that a repeat expiry coincides with the release, `rel_o[0] = 1` and `stb_o[0] = 0` on that cycle.
5. **Independence:** ch0 pressed at edge 1 and ch1 at edge 3 → `stb_o[0]` at edge 6 and `stb_o[1]` at edge 8. Each channel follows its own repeat schedule.
6. **Reset mid-hold and REPEAT_EN=0:**
   - Reset asserted during REPEAT → outputs are 0 on the next cycle. With the button still held, a new `stb_o` occurs 6 edges after reset deassertion.
   - Rerun scenario 2 with `REPEAT_EN=0` → only the edge-6 strobe occurs.

Source files
------------

// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw button levels in, debounced levels and
// single-cycle press/repeat and release strobes out.
//   btn_i : raw asynchronous button levels, 1 = pressed
//   lvl_o : debounced level per channel
//   stb_o : one-cycle strobe on press and on each auto-repeat
//   rel_o : one-cycle strobe on debounced release
// master drives btn_i (board side), slave is the conditioner.
interface btn_conditioner_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] btn_i;
  logic [CHANNELS-1:0] lvl_o;
  logic [CHANNELS-1:0] stb_o;
  logic [CHANNELS-1:0] rel_o;

  modport master (output btn_i, input lvl_o, stb_o, rel_o);
  modport slave  (input btn_i, output lvl_o, stb_o, rel_o);
endinterface

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner. Each channel synchronises its raw
// button, debounces it with a stability counter and emits a press strobe,
// an optional auto-repeat strobe train while held, and a release strobe.
//   clk_i  : clock, all state on rising edge
//   rst_ni : synchronous active-low reset
//   bus    : btn_conditioner_if.slave (btn_i in; lvl_o, stb_o, rel_o out)

// One conditioner channel.
//   btn : raw button level     lvl : debounced level
//   stb : press/repeat strobe  rel : release strobe
module btn_chan #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn,
  output logic lvl,
  output logic stb,
  output logic rel
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  state_t        state;
  logic          s1, s;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic          settle, rise, fall;

  // The level flip is decoded combinationally so the press/release strobe
  // lands on the same edge that lvl changes, not one cycle later.
  assign settle = (s != lvl) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise   = settle & s;
  assign fall   = settle & ~s;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1    <= 1'b0;
      s     <= 1'b0;
      lvl   <= 1'b0;
      cnt   <= '0;
      rcnt  <= '0;
      stb   <= 1'b0;
      rel   <= 1'b0;
      state <= IDLE;
    end else begin
      s1  <= btn;
      s   <= s1;
      stb <= 1'b0;
      rel <= 1'b0;

      if (s == lvl)    cnt <= '0;
      else if (settle) begin
        lvl <= s;
        cnt <= '0;
      end else         cnt <= cnt + 1'b1;

      case (state)
        IDLE: if (rise) begin
          state <= HELD;
          stb   <= 1'b1;
          rcnt  <= RW'(REPEAT_DELAY - 1);
        end
        // Release is checked first so it beats a coinciding repeat expiry.
        HELD: if (fall) begin
          state <= IDLE;
          rel   <= 1'b1;
          rcnt  <= '0;
        end else if (rcnt != '0) begin
          rcnt <= rcnt - 1'b1;
        end else if (REPEAT_EN != 0) begin
          state <= REPEAT;
          stb   <= 1'b1;
          rcnt  <= RW'(REPEAT_PERIOD - 1);
        end
        REPEAT: if (fall) begin
          state <= IDLE;
          rel   <= 1'b1;
          rcnt  <= '0;
        end else if (rcnt != '0) begin
          rcnt <= rcnt - 1'b1;
        end else begin
          stb  <= 1'b1;
          rcnt <= RW'(REPEAT_PERIOD - 1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module btn_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input logic               clk_i,
  input logic               rst_ni,
  btn_conditioner_if.slave  bus
);
  if (CHANNELS < 1)        begin : g_bad_ch  $error("CHANNELS must be >= 1");        end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db  $error("DEBOUNCE_CYCLES must be >= 1"); end
  if (REPEAT_DELAY < 1)    begin : g_bad_rd  $error("REPEAT_DELAY must be >= 1");    end
  if (REPEAT_PERIOD < 1)   begin : g_bad_rp  $error("REPEAT_PERIOD must be >= 1");   end
  if (REPEAT_EN != 0 && REPEAT_EN != 1) begin : g_bad_re $error("REPEAT_EN must be 0 or 1"); end

  logic [CHANNELS-1:0] lvl, stb, rel;

  btn_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_chan [CHANNELS-1:0] (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn    (bus.btn_i),
    .lvl    (lvl),
    .stb    (stb),
    .rel    (rel)
  );

  assign bus.lvl_o = lvl;
  assign bus.stb_o = stb;
  assign bus.rel_o = rel;
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus a randomized phase, all
// checked each cycle against a run-length/age based reference model. Two
// DUTs share the button stimulus: one with auto-repeat, one without.
module tb_btn_conditioner;
  localparam int CH = 2, DC = 4, RD = 10, RP = 3;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [CH-1:0] btn = '0;
  always #5 clk_i = ~clk_i;

  btn_conditioner_if #(.CHANNELS(CH)) bus_r();
  btn_conditioner_if #(.CHANNELS(CH)) bus_n();
  assign bus_r.btn_i = btn;
  assign bus_n.btn_i = btn;

  btn_conditioner #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut_r (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_r.slave));
  btn_conditioner #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut_n (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_n.slave));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: delay line for the synchroniser, length of the current
  // disagreement run for debouncing, and age since press for repeats.
  logic    h1 [CH];
  logic    h2 [CH];
  logic    m_lvl [CH];
  int      run [CH];
  logic    held [CH];
  int      age [CH];
  logic [CH-1:0] e_lvl = '0, e_stb_r = '0, e_stb_n = '0, e_rel = '0;

  initial for (int c = 0; c < CH; c++) begin
    h1[c] = 0; h2[c] = 0; m_lvl[c] = 0; run[c] = 0; held[c] = 0; age[c] = 0;
  end

  task automatic model(input logic rst, input logic [CH-1:0] b);
    e_stb_r = '0; e_stb_n = '0; e_rel = '0;
    for (int c = 0; c < CH; c++) begin
      logic s_old, ev;
      if (!rst) begin
        h1[c] = 0; h2[c] = 0; m_lvl[c] = 0; run[c] = 0; held[c] = 0; age[c] = 0;
      end else begin
        s_old = h2[c]; h2[c] = h1[c]; h1[c] = b[c]; ev = 0;
        if (s_old !== m_lvl[c]) begin
          run[c]++;
          if (run[c] == DC) begin
            ev = 1; run[c] = 0; m_lvl[c] = s_old;
            if (s_old) begin
              held[c] = 1; age[c] = 0; e_stb_r[c] = 1; e_stb_n[c] = 1;
            end else begin
              held[c] = 0; e_rel[c] = 1;
            end
          end
        end else run[c] = 0;
        if (!ev && held[c]) begin
          age[c]++;
          if (age[c] >= RD && (age[c] - RD) % RP == 0) e_stb_r[c] = 1;
        end
      end
      e_lvl[c] = m_lvl[c];
    end
  endtask

  // Per-scenario strobe history, indexed by edge number within the window.
  int k = 0;
  logic [63:0] h_stb0, h_stb1, h_rel0, h_stbn0;

  task automatic clear_hist();
    k = 0; h_stb0 = '0; h_stb1 = '0; h_rel0 = '0; h_stbn0 = '0;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
    model(rst_ni, btn);
    chk("lvl_r", 32'(bus_r.lvl_o), 32'(e_lvl));
    chk("stb_r", 32'(bus_r.stb_o), 32'(e_stb_r));
    chk("rel_r", 32'(bus_r.rel_o), 32'(e_rel));
    chk("lvl_n", 32'(bus_n.lvl_o), 32'(e_lvl));
    chk("stb_n", 32'(bus_n.stb_o), 32'(e_stb_n));
    chk("rel_n", 32'(bus_n.rel_o), 32'(e_rel));
    k++;
    if (k < 64) begin
      h_stb0[k]  = bus_r.stb_o[0];
      h_stb1[k]  = bus_r.stb_o[1];
      h_rel0[k]  = bus_r.rel_o[0];
      h_stbn0[k] = bus_n.stb_o[0];
    end
  endtask

  task automatic idle(input int n);
    btn = '0;
    repeat (n) step();
  endtask

  function automatic logic [31:0] rep_mask(input int p, input int lim);
    logic [31:0] m;
    m = '0;
    m[p] = 1'b1;
    for (int t = p + RD; t <= lim; t += RP) m[t] = 1'b1;
    return m;
  endfunction

  int dur [CH];

  initial begin
    // 1: reset with both buttons held
    btn = 2'b11; rst_ni = 1'b0;
    repeat (3) begin
      step();
      chk("rst_outs", {26'd0, bus_r.lvl_o, bus_r.stb_o, bus_r.rel_o}, 32'd0);
    end
    rst_ni = 1'b1;
    clear_hist();
    repeat (8) step();
    chk("rst_press0", 32'(h_stb0[9:0]), 32'd1 << 6);
    chk("rst_press1", 32'(h_stb1[9:0]), 32'd1 << 6);
    idle(20);

    // 2: clean press and hold, then release
    clear_hist(); btn = 2'b01;
    repeat (30) step();
    chk("hold_stb0", h_stb0[31:0],
        (32'd1 << 6) | (32'd1 << 16) | (32'd1 << 19) | (32'd1 << 22) | (32'd1 << 25) | (32'd1 << 28));
    chk("hold_stb1", h_stb1[31:0], 32'd0);
    chk("hold_rel0", h_rel0[31:0], 32'd0);
    chk("norep_stb0", h_stbn0[31:0], 32'd1 << 6);
    clear_hist(); btn = 2'b00;
    repeat (12) step();
    chk("rel_edge", h_rel0[31:0], 32'd1 << 6);
    chk("rel_stb0", h_stb0[31:0], (32'd1 << 1) | (32'd1 << 4));
    idle(20);

    // 3: bounce then settle high
    clear_hist();
    for (int i = 0; i < 12; i++) begin
      btn[0] = ((i / 2) % 2) == 0;
      step();
    end
    chk("bounce_quiet", h_stb0[31:0], 32'd0);
    clear_hist(); btn[0] = 1'b1;
    repeat (15) step();
    chk("bounce_settle", 32'(h_stb0[15:0]), 32'd1 << 6);
    idle(20);

    // 4a: short glitch
    clear_hist(); btn = 2'b01;
    repeat (3) step();
    btn = 2'b00;
    repeat (15) step();
    chk("glitch_stb", h_stb0[31:0], 32'd0);
    chk("glitch_rel", h_rel0[31:0], 32'd0);

    // 4b: release coinciding with a repeat expiry (edge 37)
    clear_hist(); btn = 2'b01;
    repeat (31) step();
    btn = 2'b00;
    repeat (12) step();
    chk("coin_rel", 32'(h_rel0[37]), 32'd1);
    chk("coin_stb", 32'(h_stb0[37]), 32'd0);
    idle(20);

    // 5: independent channels
    clear_hist(); btn = 2'b01;
    repeat (2) step();
    btn = 2'b11;
    repeat (29) step();
    chk("ind_stb0", h_stb0[31:0], rep_mask(6, 31));
    chk("ind_stb1", h_stb1[31:0], rep_mask(8, 31));
    idle(20);

    // 6: reset while repeating, button still held
    btn = 2'b01;
    repeat (25) step();
    rst_ni = 1'b0;
    step();
    chk("midrst_outs", {26'd0, bus_r.lvl_o, bus_r.stb_o, bus_r.rel_o}, 32'd0);
    rst_ni = 1'b1;
    clear_hist();
    repeat (8) step();
    chk("midrst_press", 32'(h_stb0[9:0]), 32'd1 << 6);
    idle(20);

    // Randomized phase: per-channel hold times around the debounce window
    for (int c = 0; c < CH; c++) dur[c] = 0;
    repeat (2000) begin
      for (int c = 0; c < CH; c++) begin
        if (dur[c] == 0) begin
          btn[c] = ~btn[c];
          dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40))
                                               : int'($urandom_range(1, 8));
        end
        dur[c]--;
      end
      rst_ni = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
